// File: rtl/cmul_add_seq.sv
// Sequential complex-multiply combine stage: folds four partial products into re/im
// over two cycles using one external shared W-bit adder, with valid/ready handshakes.
module cmul_add_seq #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] ac,
  input  logic [W-1:0] bd,
  input  logic [W-1:0] ad,
  input  logic [W-1:0] bc,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] re,
  output logic [W-1:0] im,
  output logic         ovf_re,
  output logic         ovf_im,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  output logic         add_cin,
  input  logic [W-1:0] add_s,
  input  logic         add_cout
);

  typedef enum logic [1:0] {IDLE, RE, IM, DONE} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] ac_q, ac_d, bd_q, bd_d, ad_q, ad_d, bc_q, bc_d;
  logic         op_q, op_d;
  logic [W-1:0] re_q, re_d, im_q, im_d;
  logic         ovf_re_q, ovf_re_d, ovf_im_q, ovf_im_d;

  logic [W-1:0] opnd_x, opnd_y;
  logic         is_sub;
  logic         ovf;
  logic         unused_add_cout;

  assign unused_add_cout = add_cout;

  // Adder steering; opnd_x/opnd_y are the true operands before any inversion.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    opnd_x  = '0;
    opnd_y  = '0;
    is_sub  = 1'b0;
    case (state_q)
      RE: begin
        opnd_x  = ac_q;
        opnd_y  = bd_q;
        is_sub  = !op_q;
        add_a   = ac_q;
        add_b   = op_q ? bd_q : ~bd_q;
        add_cin = !op_q;
      end
      IM: begin
        opnd_x  = op_q ? bc_q : ad_q;
        opnd_y  = op_q ? ad_q : bc_q;
        is_sub  = op_q;
        add_a   = opnd_x;
        add_b   = op_q ? ~ad_q : bc_q;
        add_cin = op_q;
      end
      default: ;
    endcase
  end

  assign ovf = is_sub
             ? ((opnd_x[W-1] != opnd_y[W-1]) && (add_s[W-1] != opnd_x[W-1]))
             : ((opnd_x[W-1] == opnd_y[W-1]) && (add_s[W-1] != opnd_x[W-1]));

  assign in_ready = (state_q == IDLE) && !rst;

  always_comb begin
    state_d  = state_q;
    ac_d     = ac_q;
    bd_d     = bd_q;
    ad_d     = ad_q;
    bc_d     = bc_q;
    op_d     = op_q;
    re_d     = re_q;
    im_d     = im_q;
    ovf_re_d = ovf_re_q;
    ovf_im_d = ovf_im_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          ac_d    = ac;
          bd_d    = bd;
          ad_d    = ad;
          bc_d    = bc;
          op_d    = op;
          state_d = RE;
        end
      end
      RE: begin
        re_d     = add_s;
        ovf_re_d = ovf;
        state_d  = IM;
      end
      IM: begin
        im_d     = add_s;
        ovf_im_d = ovf;
        state_d  = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ac_q     <= '0;
      bd_q     <= '0;
      ad_q     <= '0;
      bc_q     <= '0;
      op_q     <= 1'b0;
      re_q     <= '0;
      im_q     <= '0;
      ovf_re_q <= 1'b0;
      ovf_im_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ac_q     <= ac_d;
      bd_q     <= bd_d;
      ad_q     <= ad_d;
      bc_q     <= bc_d;
      op_q     <= op_d;
      re_q     <= re_d;
      im_q     <= im_d;
      ovf_re_q <= ovf_re_d;
      ovf_im_q <= ovf_im_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign re        = re_q;
  assign im        = im_q;
  assign ovf_re    = ovf_re_q;
  assign ovf_im    = ovf_im_q;

endmodule
